// File: rtl/uart_mmio_responder.sv
// Serial MMIO responder on the data-SRAM request port: TX byte FIFO + 8N1 transmitter, 8N1 receiver with holding register.
// Optional sticky receive-overrun flag in STATUS bit 2 when UART_RX_OVERRUN_EN is defined.
module uart_mmio_responder #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 9600,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_sel,
  input  logic        io_sram_en,
  input  logic        io_sram_we,
  input  logic [3:0]  io_sram_wmask,
  input  logic [19:0] io_sram_addr,
  input  logic [31:0] io_sram_din,
  output logic [31:0] io_sram_dout,
  output logic        txd,
  input  logic        rxd
);

  localparam int DIV_CALC = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int DIV      = (DIV_CALC < 4) ? 4 : DIV_CALC;
  localparam int CW       = $clog2(DIV);
  localparam int AW       = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode
  logic acc, data_rd, stat_rd, data_wr;
  assign acc     = io_sel & io_sram_en;
  assign data_rd = acc & ~io_sram_we & ~io_sram_addr[0];
  assign stat_rd = acc & ~io_sram_we &  io_sram_addr[0];
  assign data_wr = acc &  io_sram_we & ~io_sram_addr[0] & io_sram_wmask[0];

  logic unused_bits;
  assign unused_bits = ^{io_sram_addr[19:1], io_sram_din[31:8], io_sram_wmask[3:1]};

  // TX FIFO: extra pointer bit distinguishes full from empty
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, tx_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
  assign push       = data_wr & (~fifo_full | tx_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= io_sram_din[7:0];
  end

  // TX FSM
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_q, txd_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
          txd_n      = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
            tx_bit_n   = tx_bit + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
            txd_n      = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign txd = txd_q;

  // RX synchronizer and edge history
  logic rx_meta, rxs, rxs_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // RX FSM
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_load    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rxs_prev && !rxs) rx_state_n = RX_START;
      end
      RX_START: begin
        // Half a bit in: still low means a real start bit, high means a glitch
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxs, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_load    = rxs;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Holding register; a completing byte wins over a concurrent DATA read clear
  logic       rx_valid;
  logic [7:0] rx_byte;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else if (rx_load) begin
      rx_valid <= 1'b1;
      rx_byte  <= rx_shift;
    end else if (data_rd) begin
      rx_valid <= 1'b0;
    end
  end

  logic ovr;
`ifdef UART_RX_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ovr <= 1'b0;
    else if (rx_load && rx_valid && !data_rd) ovr <= 1'b1;
    else if (stat_rd)                        ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
`endif

  // Read data with the same one-cycle latency as the SRAM path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       io_sram_dout <= '0;
    else if (stat_rd) io_sram_dout <= {29'b0, ovr, rx_valid, ~fifo_full};
    else if (data_rd) io_sram_dout <= {24'b0, rx_byte};
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Bench for uart_mmio_responder: frame-level TX/RX model checked every cycle, plus hand-computed literal checks.
module tb_uart_mmio_responder;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int DIV      = 10;
  localparam int FRAME    = 10 * DIV;
`ifdef UART_RX_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        io_sel;
  logic        io_sram_en;
  logic        io_sram_we;
  logic [3:0]  io_sram_wmask;
  logic [19:0] io_sram_addr;
  logic [31:0] io_sram_din;
  logic [31:0] io_sram_dout;
  logic        txd;
  logic        rxd;

  uart_mmio_responder #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .TX_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_sel(io_sel),
    .io_sram_en(io_sram_en),
    .io_sram_we(io_sram_we),
    .io_sram_wmask(io_sram_wmask),
    .io_sram_addr(io_sram_addr),
    .io_sram_din(io_sram_din),
    .io_sram_dout(io_sram_dout),
    .txd(txd),
    .rxd(rxd)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: TX queue + frame position, RX holding register fed by driver events
  logic [7:0]  exp_q[$];
  int          m_pos = -1;
  logic [7:0]  m_byte = '0;
  logic        m_rx_valid = 1'b0;
  logic [7:0]  m_rx_byte = '0;
  logic        m_ovr = 1'b0;
  logic [31:0] m_dout = '0;
  logic [7:0]  ev_bytes [64];
  int          ev_cnt = 0;
  int          ev_seen = 0;

  function automatic logic exp_txd();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  always @(posedge clk) begin
    logic acc, pop_now, push_ok;
    if (!rst_n) begin
      exp_q.delete();
      m_pos      = -1;
      m_rx_valid = 1'b0;
      m_rx_byte  = '0;
      m_ovr      = 1'b0;
      m_dout     = '0;
      ev_seen    = ev_cnt;
    end else begin
      acc = io_sel & io_sram_en;
      while (ev_seen < ev_cnt) begin
        if (OVR_EN && m_rx_valid) m_ovr = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_byte  = ev_bytes[ev_seen];
        ev_seen++;
      end
      if (acc && !io_sram_we) begin
        if (io_sram_addr[0]) begin
          m_dout = {29'b0, m_ovr, m_rx_valid, (exp_q.size() < DEPTH)};
          m_ovr  = 1'b0;
        end else begin
          m_dout     = {24'b0, m_rx_byte};
          m_rx_valid = 1'b0;
        end
      end
      pop_now = ((m_pos < 0) || (m_pos == FRAME - 1)) && (exp_q.size() > 0);
      push_ok = acc && io_sram_we && !io_sram_addr[0] && io_sram_wmask[0] &&
                ((exp_q.size() < DEPTH) || pop_now);
      if ((m_pos < 0) || (m_pos == FRAME - 1)) begin
        if (pop_now) begin
          m_byte = exp_q.pop_front();
          m_pos  = 0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
      if (push_ok) exp_q.push_back(io_sram_din[7:0]);
    end
  end

  // Scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check32("txd", {31'b0, txd}, {31'b0, exp_txd()});
      check32("dout", io_sram_dout, m_dout);
    end
  end

  // Driver tasks
  task automatic bus_idle();
    @(negedge clk);
    io_sel = 1'b0; io_sram_en = 1'b0; io_sram_we = 1'b0;
    io_sram_wmask = 4'h0; io_sram_addr = '0; io_sram_din = '0;
  endtask

  task automatic wr(input logic reg_sel, input logic [7:0] data, input logic [3:0] mask);
    @(negedge clk);
    io_sel = 1'b1; io_sram_en = 1'b1; io_sram_we = 1'b1;
    io_sram_wmask = mask; io_sram_addr = {19'h5a5a5, reg_sel};
    io_sram_din = {24'hABCDEF, data};
  endtask

  task automatic rd(input logic reg_sel, output logic [31:0] v);
    @(negedge clk);
    io_sel = 1'b1; io_sram_en = 1'b1; io_sram_we = 1'b0;
    io_sram_wmask = 4'hF; io_sram_addr = {19'h00000, reg_sel};
    bus_idle();
    v = io_sram_dout;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i];
      wait_cycles(DIV);
    end
    rxd = 1'b1;
    wait_cycles(3);
    if (stop_bit) begin
      ev_bytes[ev_cnt] = b;
      ev_cnt++;
    end
  endtask

  // Directed sequence
  initial begin
    logic [31:0] v;
    logic [9:0]  pat55;
    rst_n = 1'b0; rxd = 1'b1;
    io_sel = 1'b0; io_sram_en = 1'b0; io_sram_we = 1'b0;
    io_sram_wmask = 4'h0; io_sram_addr = '0; io_sram_din = '0;
    wait_cycles(3);
    check32("reset_dout", io_sram_dout, 32'h0);
    check32("reset_txd", {31'b0, txd}, 32'h1);
    rst_n = 1'b1;
    wait_cycles(2);

    rd(1'b1, v);
    check32("status_after_reset", v, 32'h1);

    // Single 0x55 frame, sampled mid-bit
    pat55 = 10'b1010101010;
    wr(1'b0, 8'h55, 4'h1);
    bus_idle();
    wait_cycles(1);
    check32("tx55_start_edge", {31'b0, txd}, 32'h0);
    wait_cycles(5);
    for (int j = 0; j < 10; j++) begin
      check32("tx55_bit", {31'b0, txd}, {31'b0, pat55[j]});
      if (j < 9) wait_cycles(DIV);
    end
    wait_cycles(5);
    check32("tx55_idle_after", {31'b0, txd}, 32'h1);
    wait_cycles(10);

    // Ignored writes: STATUS target and wmask[0]=0
    wr(1'b1, 8'h77, 4'hF);
    wr(1'b0, 8'h66, 4'hE);
    bus_idle();
    wait_cycles(5);
    check32("ignored_write_txd", {31'b0, txd}, 32'h1);
    rd(1'b1, v);
    check32("ignored_write_status", v, 32'h1);

    // Five back-to-back, sixth dropped while full
    wr(1'b0, 8'h11, 4'h1);
    wr(1'b0, 8'h22, 4'h1);
    wr(1'b0, 8'h33, 4'h1);
    wr(1'b0, 8'h44, 4'h1);
    wr(1'b0, 8'h5A, 4'h1);
    wr(1'b0, 8'hEE, 4'h1);
    bus_idle();
    rd(1'b1, v);
    check32("status_full", v, 32'h0);
    wait_cycles(5 * FRAME + 20);
    rd(1'b1, v);
    check32("status_drained", v, 32'h1);

    // Receive 0xA3
    send_rx(8'hA3, 1'b1);
    rd(1'b1, v);
    check32("rx_status_valid", v, 32'h2 | 32'h1);
    rd(1'b0, v);
    check32("rx_data_a3", v, 32'h000000A3);
    rd(1'b1, v);
    check32("rx_status_cleared", v, 32'h1);

    // Glitch shorter than half a bit
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(30);
    rd(1'b1, v);
    check32("glitch_status", v, 32'h1);

    // Framing error discards the byte
    send_rx(8'h5C, 1'b0);
    wait_cycles(5);
    rd(1'b1, v);
    check32("framing_status", v, 32'h1);
    rd(1'b0, v);
    check32("framing_data_old", v, 32'h000000A3);

    // Two frames without a DATA read
    send_rx(8'h3C, 1'b1);
    send_rx(8'hC5, 1'b1);
    rd(1'b1, v);
    check32("two_frames_status", v, OVR_EN ? 32'h7 : 32'h3);
    rd(1'b1, v);
    check32("two_frames_status2", v, 32'h3);
    rd(1'b0, v);
    check32("two_frames_data", v, 32'h000000C5);
    rd(1'b1, v);
    check32("final_status", v, 32'h1);

    wait_cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
